// File: rtl/mips_pc_unit.sv
// Program counter register with prioritised next-PC selection (exc > jr > jmp > brnch > pc+4).
// Define MIPS_PC_RAS_EN to add a circular return-address stack feeding jr targets.
module mips_pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [31:0]     EXC_VEC   = 32'h0000_0180,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [31:0]     inst,
    input  logic            brnch,
    input  logic            jmp,
    input  logic            link,
    input  logic            jr,
    input  logic [XLEN-1:0] rs_val,
    input  logic            exc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcplus4,
    output logic            fetch_valid,
    output logic            redirect,
    output logic            ras_used
);

    if (XLEN < 32 || RAS_DEPTH < 2 || RAS_DEPTH > 16 ||
        (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_param_check
        $error("mips_pc_unit: unsupported XLEN or RAS_DEPTH");
    end

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic [XLEN-1:0] seimm;
    logic [XLEN-1:0] bta;
    logic [XLEN-1:0] jta;
    logic [XLEN-1:0] jr_target;
    logic [XLEN-1:0] exc_target;

    logic            active;
    logic            take_jr;
    logic            take_jmp;
    logic            take_br;
    logic            ras_pop;

    assign pcplus4    = pc_q + XLEN'(4);
    assign seimm      = {{(XLEN-16){inst[15]}}, inst[15:0]};
    assign bta        = pcplus4 + (seimm << 2);
    assign jta        = {pcplus4[XLEN-1:28], inst[25:0], 2'b00};
    assign exc_target = XLEN'(EXC_VEC);

    // Control inputs only count for a valid instruction that is not stalled; exc always wins.
    always_comb begin
        active   = (state_q == ST_RUN) && !stall;
        take_jr  = active && !exc && jr;
        take_jmp = active && !exc && !jr && jmp;
        take_br  = active && !exc && !jr && !jmp && brnch;
    end

`ifdef MIPS_PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [XLEN-1:0]  ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] top_idx;
    logic             ras_push;
    logic [5:0]       unused_inst_hi;

    assign unused_inst_hi = inst[31:26];
    assign top_idx        = ptr_q - 1'b1;
    assign ras_push       = take_jmp && link;
    assign ras_pop        = take_jr && (cnt_q != '0);
    assign jr_target      = ras_pop ? ras_q[top_idx] : rs_val;

    // ptr_q is the next write slot; a push when full overwrites the oldest entry.
    always_comb begin
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (exc) begin
            cnt_d = '0;
        end else if (ras_push) begin
            ras_d[ptr_q] = pcplus4;
            ptr_d        = ptr_q + 1'b1;
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (ras_pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end
`else
    logic [6:0] unused_inputs;

    assign unused_inputs = {inst[31:26], link};
    assign ras_pop       = 1'b0;
    assign jr_target     = rs_val;
`endif

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (exc) begin
            pc_d    = exc_target;
            state_d = ST_BUBBLE;
        end else if (!stall) begin
            unique case (state_q)
                ST_RUN: begin
                    if (take_jr) begin
                        pc_d    = jr_target;
                        state_d = ST_BUBBLE;
                    end else if (take_jmp) begin
                        pc_d    = jta;
                        state_d = ST_BUBBLE;
                    end else if (take_br) begin
                        pc_d    = bta;
                        state_d = ST_BUBBLE;
                    end else begin
                        pc_d = pcplus4;
                    end
                end
                ST_BOOT, ST_BUBBLE: state_d = ST_RUN;
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            state_q <= ST_BOOT;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = !rst && (state_q == ST_RUN);
    assign redirect    = !rst && (take_jr || take_jmp || take_br || (active && exc));
    assign ras_used    = !rst && ras_pop;

endmodule
